// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared states, opcodes and control encodings for the RV64I multicycle control unit
package riscv_mc_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_EXEC_R = 5'd2,
        S_EXEC_I = 5'd3,
        S_ALU_WB = 5'd4,
        S_SHIFT  = 5'd5,
        S_ADDR   = 5'd6,
        S_MEM_RD = 5'd7,
        S_MEM_WB = 5'd8,
        S_MEM_WR = 5'd9,
        S_BRANCH = 5'd10,
        S_LUI    = 5'd11,
        S_JAL    = 5'd12,
        S_JALR   = 5'd13,
        S_TRAP   = 5'd14,
        S_HALT   = 5'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_TRAP   = 2'd2;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'd3;

    localparam logic [2:0] WB_ALUOUT = 3'd0;
    localparam logic [2:0] WB_MDR    = 3'd1;
    localparam logic [2:0] WB_IMM    = 3'd2;
    localparam logic [2:0] WB_PC     = 3'd3;
    localparam logic [2:0] WB_SHIFT  = 3'd4;

    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

    // funct3 low bits 00/01/10/11 (b/h/w/d) map onto tam 11/10/01/00
    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return ~funct3[1:0];
    endfunction

endpackage

// File: rtl/riscv_mc_decode.sv
// rtl/riscv_mc_decode.sv - combinational dispatch of the IR to the first execute state
module riscv_mc_decode
    import riscv_mc_pkg::*;
(
    input  logic [31:0] instruction,
    output state_t      dispatch_state,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] funct6;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign funct6 = instruction[31:26];

    always_comb begin
        dispatch_state = S_TRAP;
        illegal        = 1'b1;
        case (opcode)
            OP_R: begin
                if ((funct7 == 7'b0000000 &&
                     (funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b111)) ||
                    (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
                    dispatch_state = S_EXEC_R;
                    illegal        = 1'b0;
                end
            end
            OP_IMM: begin
                // RV64 shifts carry a 6-bit shamt, so only funct6 qualifies them
                case (funct3)
                    3'b000, 3'b010: begin
                        dispatch_state = S_EXEC_I;
                        illegal        = 1'b0;
                    end
                    3'b001: begin
                        if (funct6 == 6'b000000) begin
                            dispatch_state = S_SHIFT;
                            illegal        = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (funct6 == 6'b000000 || funct6 == 6'b010000) begin
                            dispatch_state = S_SHIFT;
                            illegal        = 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            OP_LOAD: begin
                if (funct3 != 3'b111) begin
                    dispatch_state = S_ADDR;
                    illegal        = 1'b0;
                end
            end
            OP_STORE: begin
                if (!funct3[2]) begin
                    dispatch_state = S_ADDR;
                    illegal        = 1'b0;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 ||
                    funct3 == 3'b100 || funct3 == 3'b101) begin
                    dispatch_state = S_BRANCH;
                    illegal        = 1'b0;
                end
            end
            OP_LUI: begin
                dispatch_state = S_LUI;
                illegal        = 1'b0;
            end
            OP_JAL: begin
                dispatch_state = S_JAL;
                illegal        = 1'b0;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    dispatch_state = S_JALR;
                    illegal        = 1'b0;
                end
            end
            OP_SYSTEM: begin
                if (instruction == EBREAK_INSN) begin
                    dispatch_state = S_HALT;
                    illegal        = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// rtl/riscv_mc_control.sv - multicycle RV64I control FSM with data-memory handshake and trap path
// Define RISCV_MC_INSTRET_EN to add the 64-bit retired-instruction counter output.
module riscv_mc_control
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_funct,
    output logic        load_reg_a,
    output logic        load_reg_b,
    output logic        load_alu_out,
    output logic        load_ir,
    output logic        load_mdr,
    output logic        write_reg,
    output logic [2:0]  mem_to_reg,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  tam,
    output logic [1:0]  shift_ctrl,
    output logic [1:0]  branch_op,
    output logic        load_epc,
    output logic        load_cause,
    output logic [1:0]  cause,
    output logic        halted,
    output logic [4:0]  state
`ifdef RISCV_MC_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    state_t             dec_state;
    logic               dec_illegal;
    logic [2:0]         funct3;
    logic               timeout_hit;

    assign funct3      = instruction[14:12];
    assign timeout_hit = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign state       = state_q;

    riscv_mc_decode u_decode (
        .instruction    (instruction),
        .dispatch_state (dec_state),
        .illegal        (dec_illegal)
    );

    // The wait counter is idle outside memory states, so on entry to TRAP it
    // records why: 0 = illegal instruction, 1 = memory timeout.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_funct     = ALU_PASS;
        load_reg_a    = 1'b0;
        load_reg_b    = 1'b0;
        load_alu_out  = 1'b0;
        load_ir       = 1'b0;
        load_mdr      = 1'b0;
        write_reg     = 1'b0;
        mem_to_reg    = WB_ALUOUT;
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        tam           = 2'b00;
        shift_ctrl    = 2'b00;
        branch_op     = 2'b00;
        load_epc      = 1'b0;
        load_cause    = 1'b0;
        cause         = CAUSE_NONE;
        halted        = 1'b0;

        case (state_q)
            S_FETCH: begin
                load_ir   = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_funct = ALU_ADD;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                load_reg_a   = 1'b1;
                load_reg_b   = 1'b1;
                load_alu_out = 1'b1;
                alu_src_b    = SRCB_IMM_SH1;
                alu_funct    = ALU_ADD;
                cnt_d        = '0;
                state_d      = dec_illegal ? S_TRAP : dec_state;
            end
            S_EXEC_R: begin
                load_alu_out = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REG;
                case ({instruction[30], funct3})
                    4'b0_000: alu_funct = ALU_ADD;
                    4'b1_000: alu_funct = ALU_SUB;
                    4'b0_111: alu_funct = ALU_AND;
                    4'b0_010: alu_funct = ALU_SLT;
                    default:  alu_funct = ALU_PASS;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                load_alu_out = 1'b1;
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_funct    = (funct3 == 3'b010) ? ALU_SLT : ALU_ADD;
                state_d      = S_ALU_WB;
            end
            S_ALU_WB: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_ALUOUT;
                state_d    = S_FETCH;
            end
            S_SHIFT: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_SHIFT;
                shift_ctrl = funct3[2] ? (instruction[30] ? 2'b10 : 2'b01) : 2'b00;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_funct    = ALU_ADD;
                load_alu_out = 1'b1;
                cnt_d        = '0;
                state_d      = (instruction[6:0] == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                dmem_read = 1'b1;
                load_mdr  = mem_ready;
                tam       = access_size(funct3);
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEM_WB: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_MDR;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                dmem_write = 1'b1;
                tam        = access_size(funct3);
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BRANCH: begin
                alu_funct     = ALU_SUB;
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                pc_write_cond = 1'b1;
                pc_src        = PC_ALUOUT;
                branch_op     = {funct3[2], funct3[2] ^ funct3[0]};
                state_d       = S_FETCH;
            end
            S_LUI: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_IMM;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_PC;
                pc_write   = 1'b1;
                pc_src     = PC_ALUOUT;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                write_reg  = 1'b1;
                mem_to_reg = WB_PC;
                pc_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_funct  = ALU_ADD;
                pc_src     = PC_ALU;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                load_epc   = 1'b1;
                load_cause = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_TRAP;
                cause      = (cnt_q == CNT_W'(1)) ? CAUSE_MEM_TIMEOUT : CAUSE_ILLEGAL;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Memory must see the access abandoned as soon as reset is applied.
        if (reset) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RISCV_MC_INSTRET_EN
    logic [63:0] instret_q, instret_d;
    logic        retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_ALU_WB, S_SHIFT, S_MEM_WB, S_BRANCH, S_LUI, S_JAL, S_JALR: retire = 1'b1;
            S_MEM_WR: retire = mem_ready;
            default:  retire = 1'b0;
        endcase
        instret_d = retire ? instret_q + 64'd1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// tb/tb_riscv_mc_control.sv - scoreboard bench: per-cycle expected control vectors compared against the FSM
module tb_riscv_mc_control;
    import riscv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, alu_src_a;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_funct, mem_to_reg;
    logic        load_reg_a, load_reg_b, load_alu_out, load_ir, load_mdr, write_reg;
    logic        dmem_read, dmem_write, load_epc, load_cause, halted;
    logic [1:0]  tam, shift_ctrl, branch_op, cause;
    logic [4:0]  state;
`ifdef RISCV_MC_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0] st;
        logic       lir, lra, lrb, lao, srca;
        logic [1:0] srcb;
        logic       wr;
        logic [2:0] m2r;
        logic       drd, dwr, mdr, pcw, pcwc;
        logic [1:0] pcs;
        logic       epc, lcause;
        logic [1:0] cause;
        logic       halted;
        logic [2:0] alu;
        logic [1:0] bop, tam, sh;
    } exp_t;

    exp_t exp_q[$];
    logic rdy_q[$];

    riscv_mc_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_funct     (alu_funct),
        .load_reg_a    (load_reg_a),
        .load_reg_b    (load_reg_b),
        .load_alu_out  (load_alu_out),
        .load_ir       (load_ir),
        .load_mdr      (load_mdr),
        .write_reg     (write_reg),
        .mem_to_reg    (mem_to_reg),
        .dmem_read     (dmem_read),
        .dmem_write    (dmem_write),
        .tam           (tam),
        .shift_ctrl    (shift_ctrl),
        .branch_op     (branch_op),
        .load_epc      (load_epc),
        .load_cause    (load_cause),
        .cause         (cause),
        .halted        (halted),
        .state         (state)
`ifdef RISCV_MC_INSTRET_EN
        ,
        .instret       (instret)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic exp_t e_st(input logic [4:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    task automatic push(input exp_t e, input logic rdy);
        exp_q.push_back(e);
        rdy_q.push_back(rdy);
    endtask

    task automatic push_fd();
        exp_t e;
        e = e_st(S_FETCH);  e.lir = 1; e.pcw = 1; e.srcb = 2'd1; e.alu = 3'd1; push(e, 1'b0);
        e = e_st(S_DECODE); e.lra = 1; e.lrb = 1; e.lao = 1; e.srcb = 2'd3; e.alu = 3'd1; push(e, 1'b0);
    endtask

    task automatic run_trace(input string name);
        exp_t e, obs;
        int   cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e         = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            #1;
            obs = '{st: state, lir: load_ir, lra: load_reg_a, lrb: load_reg_b, lao: load_alu_out,
                    srca: alu_src_a, srcb: alu_src_b, wr: write_reg, m2r: mem_to_reg,
                    drd: dmem_read, dwr: dmem_write, mdr: load_mdr, pcw: pc_write,
                    pcwc: pc_write_cond, pcs: pc_src, epc: load_epc, lcause: load_cause,
                    cause: cause, halted: halted, alu: alu_funct, bop: branch_op, tam: tam,
                    sh: shift_ctrl};
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got state=%0d vec=%h, want state=%0d vec=%h",
                         name, cyc, obs.st, obs, e.st, e);
            end
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        mem_ready   = 1'b0;
        instruction = 32'h0010_0073;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (state !== 5'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++;
        if (halted !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: halted=%b rd=%b wr=%b want 0 0 0", halted, dmem_read, dmem_write);
        end
        n_checks++;
        if (load_ir !== 1'b1 || pc_write !== 1'b1) begin
            n_fail++; $display("FAIL reset_fetch: load_ir=%b pc_write=%b want 1 1", load_ir, pc_write);
        end
        reset = 1'b0;
    endtask

    task automatic run_alu(input string name, input logic [31:0] insn, input logic [4:0] exec_st,
                           input logic [2:0] alu_f, input logic [1:0] sh);
        exp_t e;
        instruction = insn;
        push_fd();
        if (exec_st == S_SHIFT) begin
            e = e_st(S_SHIFT); e.wr = 1; e.m2r = 3'd4; e.sh = sh; push(e, 1'b0);
        end else begin
            e = e_st(exec_st); e.lao = 1; e.srca = 1; e.alu = alu_f;
            e.srcb = (exec_st == S_EXEC_I) ? 2'd2 : 2'd0;
            push(e, 1'b0);
            e = e_st(S_ALU_WB); e.wr = 1; e.m2r = 3'd0; push(e, 1'b0);
        end
        run_trace(name);
    endtask

    task automatic test_alu();
        run_alu("add",  32'h0020_81B3, S_EXEC_R, 3'd1, 2'b00);
        run_alu("sub",  32'h4020_81B3, S_EXEC_R, 3'd2, 2'b00);
        run_alu("and",  32'h0020_F1B3, S_EXEC_R, 3'd3, 2'b00);
        run_alu("slt",  32'h0020_A1B3, S_EXEC_R, 3'd4, 2'b00);
        run_alu("addi", 32'h0050_8093, S_EXEC_I, 3'd1, 2'b00);
        run_alu("slti", 32'h0050_A093, S_EXEC_I, 3'd4, 2'b00);
        run_alu("slli", 32'h0030_9093, S_SHIFT,  3'd0, 2'b00);
        run_alu("srli", 32'h0030_D093, S_SHIFT,  3'd0, 2'b01);
        run_alu("srai", 32'h4030_D093, S_SHIFT,  3'd0, 2'b10);
    endtask

    task automatic run_load(input string name, input int ready_cycle);
        exp_t e;
        instruction = 32'h0080_B283;
        push_fd();
        e = e_st(S_ADDR); e.srca = 1; e.srcb = 2'd2; e.lao = 1; e.alu = 3'd1; push(e, 1'b0);
        for (int i = 1; i <= ready_cycle; i++) begin
            e = e_st(S_MEM_RD); e.drd = 1; e.tam = 2'b00; e.mdr = (i == ready_cycle);
            push(e, i == ready_cycle);
        end
        e = e_st(S_MEM_WB); e.wr = 1; e.m2r = 3'd1; push(e, 1'b0);
        run_trace(name);
    endtask

    task automatic test_load();
        run_load("ld_wait3", 3);
        run_load("ld_last_cycle", 16);
    endtask

    task automatic test_store();
        exp_t e;
        instruction = 32'h0010_A023;
        push_fd();
        e = e_st(S_ADDR); e.srca = 1; e.srcb = 2'd2; e.lao = 1; e.alu = 3'd1; push(e, 1'b0);
        e = e_st(S_MEM_WR); e.dwr = 1; e.tam = 2'b01; push(e, 1'b1);
        run_trace("sw_fast");

        push_fd();
        e = e_st(S_ADDR); e.srca = 1; e.srcb = 2'd2; e.lao = 1; e.alu = 3'd1; push(e, 1'b0);
        for (int i = 0; i < 16; i++) begin
            e = e_st(S_MEM_WR); e.dwr = 1; e.tam = 2'b01; push(e, 1'b0);
        end
        e = e_st(S_TRAP); e.epc = 1; e.lcause = 1; e.pcw = 1; e.pcs = 2'd2; e.cause = 2'b10;
        push(e, 1'b0);
        run_trace("sw_timeout");
    endtask

    task automatic run_illegal(input string name, input logic [31:0] insn);
        exp_t e;
        instruction = insn;
        push_fd();
        e = e_st(S_TRAP); e.epc = 1; e.lcause = 1; e.pcw = 1; e.pcs = 2'd2; e.cause = 2'b01;
        push(e, 1'b0);
        run_trace(name);
    endtask

    task automatic test_illegal();
        run_illegal("ill_ones",  32'hFFFF_FFFF);
        run_illegal("ill_funct7", 32'hFE20_81B3);
        run_illegal("ill_jalr_f3", 32'h0010_9067);
    endtask

    task automatic run_branch(input string name, input logic [31:0] insn, input logic [1:0] bop);
        exp_t e;
        instruction = insn;
        push_fd();
        e = e_st(S_BRANCH); e.pcwc = 1; e.pcs = 2'd1; e.alu = 3'd2; e.srca = 1; e.srcb = 2'd0;
        e.bop = bop;
        push(e, 1'b0);
        run_trace(name);
    endtask

    task automatic test_branch();
        run_branch("beq", 32'h0000_0863, 2'b00);
        run_branch("bne", 32'h0000_1863, 2'b01);
        run_branch("blt", 32'h0000_4863, 2'b11);
        run_branch("bge", 32'h0000_5863, 2'b10);
    endtask

    task automatic test_upper_jump();
        exp_t e;
        instruction = 32'h1234_50B7;
        push_fd();
        e = e_st(S_LUI); e.wr = 1; e.m2r = 3'd2; push(e, 1'b0);
        run_trace("lui");
        instruction = 32'h0080_00EF;
        push_fd();
        e = e_st(S_JAL); e.wr = 1; e.m2r = 3'd3; e.pcw = 1; e.pcs = 2'd1; push(e, 1'b0);
        run_trace("jal");
        instruction = 32'h0000_80E7;
        push_fd();
        e = e_st(S_JALR); e.wr = 1; e.m2r = 3'd3; e.pcw = 1; e.pcs = 2'd0;
        e.srca = 1; e.srcb = 2'd2; e.alu = 3'd1;
        push(e, 1'b0);
        run_trace("jalr");
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        instruction = 32'h0080_B283;
        push_fd();
        e = e_st(S_ADDR); e.srca = 1; e.srcb = 2'd2; e.lao = 1; e.alu = 3'd1; push(e, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e = e_st(S_MEM_RD); e.drd = 1; push(e, 1'b0);
        end
        run_trace("ld_before_reset");
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== 5'd0) begin n_fail++; $display("FAIL mid_reset_state: got %0d want 0", state); end
        n_checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_strobes: rd=%b wr=%b want 0 0", dmem_read, dmem_write);
        end
        reset = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e;
        instruction = 32'h0010_0073;
        push_fd();
        for (int i = 0; i < 20; i++) begin
            e = e_st(S_HALT); e.halted = 1; push(e, 1'b0);
        end
        run_trace("ebreak_halt");
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state !== 5'd0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: state=%0d halted=%b want 0 0", state, halted);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_illegal();
        test_branch();
        test_upper_jump();
        test_reset_mid_access();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
